register_file_nbit: RTL and testbench

//   Parametrised multi-register storage, successor to the single 8-bit enable register.

---
 rtl/tmp8_pkg.sv | 17 +
 rtl/incdec_unit.sv | 31 +++
 rtl/register_file_nbit.sv | 90 +++++++++
 tb/tb_register_file_nbit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmp8_pkg.sv
// Shared TMP8 datapath constants: default register width and register index names
// used by the decoder, the register file and its bench.
package tmp8_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int NUM_REGS_DEF = 8;

  localparam int REG_ACC = 0;
  localparam int REG_X   = 1;
  localparam int REG_SP  = NUM_REGS_DEF - 1;

  // The stack pointer is always the top register, whatever the file size.
  function automatic int reg_sp(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/incdec_unit.sv
// Combinational +1/-1 adder for pointer registers; flags wrap-around at the word boundary.
module incdec_unit #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wrap
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // The extra top bit carries out on all-ones+1 and borrows out on 0-1.
  assign w_sum  = {1'b0, i_data} + (DATA_W+1)'(1);
  assign w_diff = {1'b0, i_data} - (DATA_W+1)'(1);

  always_comb begin
    o_data = i_data;
    o_wrap = 1'b0;
    if (i_inc && !i_dec) begin
      o_data = w_sum[DATA_W-1:0];
      o_wrap = w_sum[DATA_W];
    end else if (i_dec && !i_inc) begin
      o_data = w_diff[DATA_W-1:0];
      o_wrap = w_diff[DATA_W];
    end
  end

endmodule

// File: rtl/register_file_nbit.sv
// NUM_REGS x DATA_W register file: one write port, two combinational read ports and an
// in-place inc/dec port with a registered one-cycle wrap pulse.
module register_file_nbit
  import tmp8_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_R0  = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [AW-1:0]     i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic              i_inc_en,
  input  logic              i_dec_en,
  input  logic [AW-1:0]     i_id_addr,
  output logic              o_id_wrap
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_id_wrap;

  logic              w_wr_ok;
  logic              w_ra_legal;
  logic              w_rb_legal;
  logic              w_id_legal;
  logic              w_id_ok;
  logic [DATA_W-1:0] w_id_cur;
  logic [DATA_W-1:0] w_id_next;
  logic              w_id_wrap;

  // An address is storage-backed when it is inside the file and is not a hardwired R0.
  function automatic logic addr_legal(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NUM_REGS)) && !(ZERO_R0 != 0 && a == '0);
  endfunction

  assign w_wr_ok    = i_we && addr_legal(i_waddr);
  assign w_ra_legal = addr_legal(i_ra_addr);
  assign w_rb_legal = addr_legal(i_rb_addr);
  assign w_id_legal = addr_legal(i_id_addr);

  assign o_ra_data = !w_ra_legal ? '0 :
                     (BYPASS != 0 && w_wr_ok && i_waddr == i_ra_addr) ? i_wdata :
                     r_regs[i_ra_addr];
  assign o_rb_data = !w_rb_legal ? '0 :
                     (BYPASS != 0 && w_wr_ok && i_waddr == i_rb_addr) ? i_wdata :
                     r_regs[i_rb_addr];

  // A write to the same register takes priority and silently drops the inc/dec.
  assign w_id_cur = w_id_legal ? r_regs[i_id_addr] : '0;
  assign w_id_ok  = (i_inc_en ^ i_dec_en) && w_id_legal &&
                    !(w_wr_ok && i_waddr == i_id_addr);

  incdec_unit #(
    .DATA_W (DATA_W)
  ) u_incdec (
    .i_data (w_id_cur),
    .i_inc  (i_inc_en),
    .i_dec  (i_dec_en),
    .o_data (w_id_next),
    .o_wrap (w_id_wrap)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_id_wrap <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_regs[i_waddr] <= i_wdata;
      end
      if (w_id_ok) begin
        r_regs[i_id_addr] <= w_id_next;
      end
      r_id_wrap <= w_id_ok && w_id_wrap;
    end
  end

  assign o_id_wrap = r_id_wrap;

endmodule

// File: tb/tb_register_file_nbit.sv
// Scoreboard bench: three register-file configurations share one stimulus stream and are
// compared against an array-based reference model.
module tb_register_file_nbit;
  import tmp8_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we, inc, dec;
  logic [2:0]  waddr, id, ra, rb;
  logic [15:0] wdata;

  logic [7:0]  ra_a, rb_a, ra_b, rb_b;
  logic [15:0] ra_c, rb_c;
  logic        wr_a, wr_b, wr_c;

  // 0: defaults (8x8, bypass); 1: 8-bit x6, ZERO_R0, no bypass; 2: 16-bit x5, bypass
  register_file_nbit #(.DATA_W(8), .NUM_REGS(8), .ZERO_R0(0), .BYPASS(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata[7:0]),
    .i_ra_addr(ra), .o_ra_data(ra_a), .i_rb_addr(rb), .o_rb_data(rb_a),
    .i_inc_en(inc), .i_dec_en(dec), .i_id_addr(id), .o_id_wrap(wr_a));

  register_file_nbit #(.DATA_W(8), .NUM_REGS(6), .ZERO_R0(1), .BYPASS(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata[7:0]),
    .i_ra_addr(ra), .o_ra_data(ra_b), .i_rb_addr(rb), .o_rb_data(rb_b),
    .i_inc_en(inc), .i_dec_en(dec), .i_id_addr(id), .o_id_wrap(wr_b));

  register_file_nbit #(.DATA_W(16), .NUM_REGS(5), .ZERO_R0(0), .BYPASS(1)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_ra_addr(ra), .o_ra_data(ra_c), .i_rb_addr(rb), .o_rb_data(rb_c),
    .i_inc_en(inc), .i_dec_en(dec), .i_id_addr(id), .o_id_wrap(wr_c));

  int nr   [3] = '{8, 6, 5};
  int mask [3] = '{'hFF, 'hFF, 'hFFFF};
  int zr   [3] = '{0, 1, 0};
  int bp   [3] = '{1, 0, 1};

  int m  [3][8];
  bit mw [3];

  typedef struct {
    int          cyc;
    int          d;
    int          k;
    logic [15:0] exp;
    string       nm;
  } chk_t;
  chk_t  sbq[$];
  string phase = "init";
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit legal(int d, int a);
    return (a < nr[d]) && !(zr[d] != 0 && a == 0);
  endfunction

  function automatic logic [15:0] exp_rd(int d, int a);
    if (!legal(d, a)) return 16'h0;
    if (bp[d] != 0 && we && legal(d, int'(waddr)) && int'(waddr) == a)
      return 16'(int'(wdata) & mask[d]);
    return 16'(m[d][a]);
  endfunction

  function automatic logic [15:0] get_out(int d, int k);
    case ({d[1:0], k[1:0]})
      4'b0000: return {8'h0, ra_a};
      4'b0001: return {8'h0, rb_a};
      4'b0010: return {15'h0, wr_a};
      4'b0100: return {8'h0, ra_b};
      4'b0101: return {8'h0, rb_b};
      4'b0110: return {15'h0, wr_b};
      4'b1000: return ra_c;
      4'b1001: return rb_c;
      default: return {15'h0, wr_c};
    endcase
  endfunction

  task automatic push(int d, int k, logic [15:0] e);
    chk_t c;
    c.cyc = cyc;
    c.d   = d;
    c.k   = k;
    c.exp = e;
    c.nm  = phase;
    sbq.push_back(c);
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        for (int a = 0; a < 8; a++) m[d][a] = 0;
        mw[d] = 1'b0;
      end else begin
        bit wok  = we && legal(d, int'(waddr));
        bit idok = (inc ^ dec) && legal(d, int'(id)) && !(wok && waddr == id);
        int old  = m[d][int'(id)];
        bit nw   = 1'b0;
        if (wok) m[d][int'(waddr)] = int'(wdata) & mask[d];
        if (idok) begin
          if (inc) begin
            nw = (old == mask[d]);
            m[d][int'(id)] = (old + 1) & mask[d];
          end else begin
            nw = (old == 0);
            m[d][int'(id)] = (old - 1) & mask[d];
          end
        end
        mw[d] = nw;
      end
    end
  endtask

  task automatic step(bit check);
    if (check) begin
      for (int d = 0; d < 3; d++) begin
        push(d, 0, exp_rd(d, int'(ra)));
        push(d, 1, exp_rd(d, int'(rb)));
        push(d, 2, {15'h0, mw[d]});
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; inc = 0; dec = 0;
    waddr = 0; id = 0; wdata = 0;
  endtask

  always @(negedge clk) begin
    chk_t        c;
    logic [15:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      c   = sbq.pop_front();
      act = get_out(c.d, c.k);
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s dut%0d port%0d cyc%0d: got %h expected %h",
                 c.nm, c.d, c.k, c.cyc, act, c.exp);
      end
    end
  end

  initial begin
    idle();
    ra = 0; rb = 0;
    rst = 1;
    step(0);

    phase = "reset";
    rst = 0;
    for (int a = 0; a < 8; a++) begin
      we = 1; waddr = 3'(a); wdata = 16'hAAAA; ra = 3'(a); rb = 3'(7 - a);
      step(1);
    end
    idle(); rst = 1; step(1);
    rst = 0;
    for (int a = 0; a < 8; a++) begin
      ra = 3'(a); rb = 3'(7 - a);
      step(1);
    end

    phase = "write_read";
    we = 1; waddr = 3; wdata = 16'h005C; ra = 0; rb = 3;
    step(1);
    idle(); ra = 3; rb = 3;
    step(1);

    phase = "wrap";
    we = 1; waddr = 7; wdata = 16'hFFFF;
    step(1);
    idle(); inc = 1; id = 7; ra = 7; rb = 7;
    step(1);
    idle(); step(1);
    step(1);
    dec = 1; id = 7;
    step(1);
    idle(); step(1);
    step(1);
    dec = 1; id = 2; ra = 2; rb = 2;
    step(1);
    idle(); step(1);

    phase = "collision";
    we = 1; waddr = 2; wdata = 16'h0010;
    step(1);
    we = 1; waddr = 2; wdata = 16'h0040; inc = 1; id = 2;
    step(1);
    idle(); inc = 1; dec = 1; id = 2;
    step(1);
    idle(); step(1);
    we = 1; waddr = 1; wdata = 16'h0033; inc = 1; id = 4; ra = 1; rb = 4;
    step(1);
    idle(); step(1);

    phase = "zero_r0_oor";
    we = 1; waddr = 0; wdata = 16'h0077; ra = 0; rb = 0;
    step(1);
    idle(); inc = 1; id = 0;
    step(1);
    idle(); step(1);
    we = 1; waddr = 7; wdata = 16'h00E1; ra = 7; rb = 5;
    step(1);
    idle(); inc = 1; id = 6; ra = 6;
    step(1);
    idle();
    for (int a = 0; a < 8; a++) begin
      ra = 3'(a); rb = 3'(7 - a);
      step(1);
    end

    phase = "reset_midop";
    rst = 1; we = 1; waddr = 1; wdata = 16'h1234; inc = 1; id = 2;
    step(1);
    idle();
    for (int a = 0; a < 8; a++) begin
      ra = 3'(a); rb = 3'(a);
      step(1);
    end

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      we    = $urandom_range(0, 1) == 1;
      waddr = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       wdata = 16'h0000;
        1:       wdata = 16'hFFFF;
        default: wdata = 16'($urandom);
      endcase
      inc = $urandom_range(0, 1) == 1;
      dec = $urandom_range(0, 2) == 0;
      id  = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 3) == 0) ? id : 3'($urandom_range(0, 7));
      step(1);
    end
    idle();
    step(1);

    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
